// File: rtl/period_averager.sv
// Single-channel period averager: synchronises and deglitches a square-wave
// input, counts clk24M cycles between filtered rising edges, and reports the
// most recent period together with a running average of 2^LOG2N periods.
module period_averager #(
    parameter int CNT_W = 24,
    parameter int LOG2N = 4,
    parameter int FILT  = 3
) (
    input  logic             clk24M,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             clr,
    output logic [CNT_W-1:0] period_last,
    output logic [CNT_W-1:0] period_avg,
    output logic             avg_valid,
    output logic             stale,
    output logic             armed
);

    localparam int               ACC_W     = CNT_W + LOG2N;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_PRE   = CNT_MAX - 1'b1;
    localparam logic [LOG2N-1:0] K_LAST    = '1;
    localparam logic [3:0]       FCNT_LAST = 4'(FILT - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             f_q, f_d;
    logic             f_dly_q, f_dly_d;
    logic [3:0]       fcnt_q, fcnt_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [LOG2N-1:0] k_q, k_d;
    logic             armed_q, armed_d;
    logic             stale_q, stale_d;
    logic             avg_valid_q, avg_valid_d;
    logic [CNT_W-1:0] period_last_q, period_last_d;
    logic [CNT_W-1:0] period_avg_q, period_avg_d;
    logic             rise;
    logic [ACC_W-1:0] acc_sum;

    // Two-flop synchroniser, then a filter that only moves the level after
    // FILT consecutive cycles of disagreement; rise marks a new filtered edge.
    always_comb begin
        sync1_d = sig_in;
        sync2_d = sync1_q;
        f_d     = f_q;
        fcnt_d  = '0;
        f_dly_d = f_q;
        if (sync2_q != f_q) begin
            if (fcnt_q == FCNT_LAST) begin
                f_d = sync2_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
        rise = f_q & ~f_dly_q;
    end

    // Period counting, sample accumulation, averaging, timeout and restart;
    // the first edge after reset/clr/timeout only arms the measurement.
    always_comb begin
        pcnt_d        = pcnt_q;
        acc_d         = acc_q;
        k_d           = k_q;
        armed_d       = armed_q;
        stale_d       = stale_q;
        avg_valid_d   = 1'b0;
        period_last_d = period_last_q;
        period_avg_d  = period_avg_q;
        acc_sum       = acc_q + {{LOG2N{1'b0}}, pcnt_q};

        if (rise) begin
            pcnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (pcnt_q != CNT_MAX) begin
            pcnt_d = pcnt_q + 1'b1;
        end

        if (clr) begin
            armed_d = 1'b0;
            acc_d   = '0;
            k_d     = '0;
            pcnt_d  = '0;
            stale_d = 1'b0;
        end else if (rise) begin
            if (!armed_q) begin
                armed_d = 1'b1;
            end else if (pcnt_q != CNT_MAX) begin
                period_last_d = pcnt_q;
                if (k_q == K_LAST) begin
                    period_avg_d = acc_sum[ACC_W-1:LOG2N];
                    avg_valid_d  = 1'b1;
                    acc_d        = '0;
                    k_d          = '0;
                    stale_d      = 1'b0;
                end else begin
                    acc_d = acc_sum;
                    k_d   = k_q + 1'b1;
                end
            end
        end else if (armed_q && pcnt_q == CNT_PRE) begin
            stale_d = 1'b1;
            armed_d = 1'b0;
            acc_d   = '0;
            k_d     = '0;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk24M) begin
        if (rst) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            f_q           <= 1'b0;
            f_dly_q       <= 1'b0;
            fcnt_q        <= '0;
            pcnt_q        <= '0;
            acc_q         <= '0;
            k_q           <= '0;
            armed_q       <= 1'b0;
            stale_q       <= 1'b0;
            avg_valid_q   <= 1'b0;
            period_last_q <= '0;
            period_avg_q  <= '0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            f_q           <= f_d;
            f_dly_q       <= f_dly_d;
            fcnt_q        <= fcnt_d;
            pcnt_q        <= pcnt_d;
            acc_q         <= acc_d;
            k_q           <= k_d;
            armed_q       <= armed_d;
            stale_q       <= stale_d;
            avg_valid_q   <= avg_valid_d;
            period_last_q <= period_last_d;
            period_avg_q  <= period_avg_d;
        end
    end

    assign period_last = period_last_q;
    assign period_avg  = period_avg_q;
    assign avg_valid   = avg_valid_q;
    assign stale       = stale_q;
    assign armed       = armed_q;

endmodule
